// File: rtl/core_pkg.sv
// Shared definitions for the RV64I core front end.
//   OP_*   : major opcodes handled by the decode stage
//   ALU_*  : ALU control codes, shared with the alu block
//   dec_state_e : load-use hazard FSM state encoding
//   dec_ctl_t   : decoded control bundle for one instruction
package core_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } dec_state_e;

    typedef struct packed {
        logic [3:0] alu_ctl;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       illegal;
        logic       uses_rs2;
    } dec_ctl_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts and sign-extends the immediate field of an
// instruction according to its major opcode. Purely combinational.
//   instr : instruction word (ILEN)
//   imm   : sign-extended immediate (XLEN); zero for R-type and unknown opcodes
module imm_gen
    import core_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_I, OP_LD: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            OP_SD:       imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            // Branch offsets are halfword aligned, so bit 0 is implicit.
            OP_BR:       imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            default:     imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage with ID/EX pipeline register and load-use hazard
// detection.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   RUN    | normal decode; a load-use hazard stalls fetch and loads a bubble
//   BUBBLE | the stalled instruction is being re-presented and decodes normally
//
// Ports:
//   i_Clk, i_Rst_n       : clock, asynchronous active-low reset
//   i_Instr, i_Valid     : instruction from fetch and its valid flag
//   i_Rs1Data, i_Rs2Data : register-file read data for rs1/rs2 of i_Instr
//   i_Flush              : kill the instruction being decoded
//   o_Stall              : combinational fetch hold request (load-use hazard)
//   o_Valid .. o_Illegal : ID/EX register contents driving the ALU and later stages
module decode_stage
    import core_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            i_Clk,
    input  logic            i_Rst_n,
    input  logic [ILEN-1:0] i_Instr,
    input  logic            i_Valid,
    input  logic [XLEN-1:0] i_Rs1Data,
    input  logic [XLEN-1:0] i_Rs2Data,
    input  logic            i_Flush,
    output logic            o_Stall,
    output logic            o_Valid,
    output logic [3:0]      o_ALUctl,
    output logic            o_ALUsrc,
    output logic [XLEN-1:0] o_Rs1,
    output logic [XLEN-1:0] o_Rs2,
    output logic [XLEN-1:0] o_Immediate,
    output logic [4:0]      o_RdAddr,
    output logic            o_RegWrite,
    output logic            o_MemRead,
    output logic            o_MemWrite,
    output logic            o_Branch,
    output logic            o_Illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_addr;

    assign opcode   = i_Instr[6:0];
    assign rd_addr  = i_Instr[11:7];
    assign funct3   = i_Instr[14:12];
    assign rs1_addr = i_Instr[19:15];
    assign rs2_addr = i_Instr[24:20];
    assign funct7   = i_Instr[31:25];

    logic [XLEN-1:0] imm;

    imm_gen #(
        .XLEN (XLEN),
        .ILEN (ILEN)
    ) u_imm_gen (
        .instr (i_Instr),
        .imm   (imm)
    );

    dec_ctl_t dec;
    logic     legal;

    always_comb begin
        dec         = '0;
        dec.alu_ctl = ALU_ADD;
        legal       = 1'b1;
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.uses_rs2  = 1'b1;
                if (funct3 == 3'b000 && funct7 == 7'b0000000)      dec.alu_ctl = ALU_ADD;
                else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec.alu_ctl = ALU_SUB;
                else if (funct3 == 3'b111 && funct7 == 7'b0000000) dec.alu_ctl = ALU_AND;
                else if (funct3 == 3'b110 && funct7 == 7'b0000000) dec.alu_ctl = ALU_OR;
                else                                               legal       = 1'b0;
            end
            OP_I: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_ctl = ALU_ADD;
                    3'b111:  dec.alu_ctl = ALU_AND;
                    3'b110:  dec.alu_ctl = ALU_OR;
                    default: legal       = 1'b0;
                endcase
            end
            OP_LD: begin
                dec.alu_src   = 1'b1;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                legal         = (funct3 == 3'b011);
            end
            OP_SD: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.uses_rs2  = 1'b1;
                legal         = (funct3 == 3'b011);
            end
            OP_BR: begin
                dec.alu_ctl  = ALU_SUB;
                dec.branch   = 1'b1;
                dec.uses_rs2 = 1'b1;
                legal        = (funct3 == 3'b000);
            end
            default: legal = 1'b0;
        endcase
        // Unsupported encodings still travel down the pipe so the trap logic
        // sees them, but with every side-effecting control suppressed.
        if (!legal) begin
            dec         = '0;
            dec.alu_ctl = ALU_ADD;
            dec.illegal = 1'b1;
        end
    end

    dec_state_e      state_q, state_d;
    logic            valid_q, valid_d;
    logic [3:0]      alu_ctl_q, alu_ctl_d;
    logic            alu_src_q, alu_src_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            branch_q, branch_d;
    logic            illegal_q, illegal_d;

    logic hazard;
    logic load;

    // Only the instruction fields and the ID/EX register feed the hazard
    // term; register-file data is kept off this path.
    assign hazard = (state_q == ST_RUN) && valid_q && mem_read_q && (rd_q != 5'd0)
                    && i_Valid
                    && ((rd_q == rs1_addr) || ((rd_q == rs2_addr) && dec.uses_rs2));

    always_comb begin
        state_d = ST_RUN;
        load    = 1'b0;
        o_Stall = 1'b0;
        if (i_Flush) begin
            state_d = ST_RUN;
        end else if (hazard) begin
            state_d = ST_BUBBLE;
            o_Stall = 1'b1;
        end else begin
            load = i_Valid;
        end
    end

    // Bubbles only clear valid and the side-effecting controls; the datapath
    // fields keep their previous contents.
    always_comb begin
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        branch_d    = 1'b0;
        illegal_d   = 1'b0;
        alu_ctl_d   = alu_ctl_q;
        alu_src_d   = alu_src_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        imm_d       = imm_q;
        rd_d        = rd_q;
        if (load) begin
            valid_d     = 1'b1;
            reg_write_d = dec.reg_write;
            mem_read_d  = dec.mem_read;
            mem_write_d = dec.mem_write;
            branch_d    = dec.branch;
            illegal_d   = dec.illegal;
            alu_ctl_d   = dec.alu_ctl;
            alu_src_d   = dec.alu_src;
            rs1_d       = i_Rs1Data;
            rs2_d       = i_Rs2Data;
            imm_d       = imm;
            rd_d        = rd_addr;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_RUN;
            valid_q     <= 1'b0;
            alu_ctl_q   <= 4'b0000;
            alu_src_q   <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            alu_ctl_q   <= alu_ctl_d;
            alu_src_q   <= alu_src_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            branch_q    <= branch_d;
            illegal_q   <= illegal_d;
        end
    end

    assign o_Valid     = valid_q;
    assign o_ALUctl    = alu_ctl_q;
    assign o_ALUsrc    = alu_src_q;
    assign o_Rs1       = rs1_q;
    assign o_Rs2       = rs2_q;
    assign o_Immediate = imm_q;
    assign o_RdAddr    = rd_q;
    assign o_RegWrite  = reg_write_q;
    assign o_MemRead   = mem_read_q;
    assign o_MemWrite  = mem_write_q;
    assign o_Branch    = branch_q;
    assign o_Illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by a
// randomized instruction stream compared against a behavioural model.
module tb_decode_stage;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n = 1'b0;
    logic [31:0] i_Instr = '0;
    logic        i_Valid = 1'b0;
    logic [63:0] i_Rs1Data = '0;
    logic [63:0] i_Rs2Data = '0;
    logic        i_Flush = 1'b0;
    logic        o_Stall, o_Valid, o_ALUsrc, o_RegWrite, o_MemRead, o_MemWrite, o_Branch, o_Illegal;
    logic [3:0]  o_ALUctl;
    logic [63:0] o_Rs1, o_Rs2, o_Immediate;
    logic [4:0]  o_RdAddr;

    decode_stage dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Instr(i_Instr), .i_Valid(i_Valid),
        .i_Rs1Data(i_Rs1Data), .i_Rs2Data(i_Rs2Data), .i_Flush(i_Flush),
        .o_Stall(o_Stall), .o_Valid(o_Valid), .o_ALUctl(o_ALUctl), .o_ALUsrc(o_ALUsrc),
        .o_Rs1(o_Rs1), .o_Rs2(o_Rs2), .o_Immediate(o_Immediate), .o_RdAddr(o_RdAddr),
        .o_RegWrite(o_RegWrite), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
        .o_Branch(o_Branch), .o_Illegal(o_Illegal)
    );

    always #5 i_Clk = ~i_Clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        bit        legal;
        bit [3:0]  aluctl;
        bit        alusrc;
        bit        rw;
        bit        mr;
        bit        mw;
        bit        br;
        bit        use2;
        bit [63:0] imm;
    } dec_t;

    // Reference model state: what the ID/EX register should hold.
    bit        m_valid, m_alusrc, m_rw, m_mr, m_mw, m_br, m_ill, m_stalled;
    bit [3:0]  m_aluctl;
    bit [63:0] m_rs1, m_rs2, m_imm;
    bit [4:0]  m_rd;
    bit        exp_stall;
    logic      obs_stall;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {im[11:5], rs2, rs1, 3'b011, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'h63};
    endfunction

    function automatic bit [63:0] sext(input longint unsigned v, input int bits);
        longint x;
        x = longint'(v);
        if (v >= (64'd1 << (bits - 1))) x = x - (longint'(1) << bits);
        return 64'(x);
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        d = '0;
        d.aluctl = 4'b0010;
        if (op == 7'b0110011) begin
            d.legal = 1; d.rw = 1; d.use2 = 1;
            if (f7 == 7'h00 && f3 == 3'd0)      d.aluctl = 4'b0010;
            else if (f7 == 7'h20 && f3 == 3'd0) d.aluctl = 4'b0110;
            else if (f7 == 7'h00 && f3 == 3'd7) d.aluctl = 4'b0000;
            else if (f7 == 7'h00 && f3 == 3'd6) d.aluctl = 4'b0001;
            else                                d.legal  = 0;
        end else if (op == 7'b0010011) begin
            d.legal = 1; d.rw = 1; d.alusrc = 1;
            d.imm = sext(64'(ins[31:20]), 12);
            if (f3 == 3'd0)      d.aluctl = 4'b0010;
            else if (f3 == 3'd7) d.aluctl = 4'b0000;
            else if (f3 == 3'd6) d.aluctl = 4'b0001;
            else                 d.legal  = 0;
        end else if (op == 7'b0000011 && f3 == 3'd3) begin
            d.legal = 1; d.rw = 1; d.mr = 1; d.alusrc = 1;
            d.imm = sext(64'(ins[31:20]), 12);
        end else if (op == 7'b0100011 && f3 == 3'd3) begin
            d.legal = 1; d.mw = 1; d.alusrc = 1; d.use2 = 1;
            d.imm = sext(64'({ins[31:25], ins[11:7]}), 12);
        end else if (op == 7'b1100011 && f3 == 3'd0) begin
            d.legal = 1; d.br = 1; d.use2 = 1; d.aluctl = 4'b0110;
            d.imm = sext(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
        end
        if (!d.legal) begin
            d = '0;
            d.aluctl = 4'b0010;
        end
        return d;
    endfunction

    function automatic bit model_stall(input logic [31:0] ins, input bit v, input bit fl);
        dec_t d;
        d = ref_decode(ins);
        return !fl && !m_stalled && m_valid && m_mr && (m_rd != 0) && v &&
               ((m_rd == ins[19:15]) || (d.use2 && m_rd == ins[24:20]));
    endfunction

    function automatic void model_reset();
        m_valid = 0; m_alusrc = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_br = 0; m_ill = 0;
        m_stalled = 0; m_aluctl = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0;
    endfunction

    function automatic void model_clock(input logic [31:0] ins, input bit v, input bit fl,
                                        input logic [63:0] d1, input logic [63:0] d2);
        dec_t d;
        bit st;
        d  = ref_decode(ins);
        st = model_stall(ins, v, fl);
        if (fl || st || !v) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_br = 0; m_ill = 0;
            m_stalled = st;
        end else begin
            m_valid = 1; m_aluctl = d.aluctl; m_alusrc = d.alusrc;
            m_rs1 = d1; m_rs2 = d2; m_imm = d.imm; m_rd = ins[11:7];
            m_rw = d.rw; m_mr = d.mr; m_mw = d.mw; m_br = d.br; m_ill = !d.legal;
            m_stalled = 0;
        end
    endfunction

    // Drives one cycle: inputs applied mid-cycle, o_Stall sampled before the
    // edge, outputs settled 1 time unit after it.
    task automatic cycle(input logic [31:0] ins, input bit v, input bit fl,
                         input logic [63:0] d1, input logic [63:0] d2);
        i_Instr = ins; i_Valid = v; i_Flush = fl; i_Rs1Data = d1; i_Rs2Data = d2;
        #2;
        exp_stall = model_stall(ins, v, fl);
        obs_stall = o_Stall;
        @(posedge i_Clk);
        model_clock(ins, v, fl, d1, d2);
        #1;
    endtask

    task automatic test_reset();
        i_Rst_n = 1'b0;
        model_reset();
        #3;
        n_vec++;
        if ({o_Valid, o_ALUctl, o_ALUsrc, o_RdAddr, o_RegWrite, o_MemRead, o_MemWrite,
             o_Branch, o_Illegal, o_Stall} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_ctl: got valid=%b ctl=%b src=%b rd=%0d rw=%b mr=%b mw=%b br=%b ill=%b stall=%b, want all 0",
                     o_Valid, o_ALUctl, o_ALUsrc, o_RdAddr, o_RegWrite, o_MemRead, o_MemWrite,
                     o_Branch, o_Illegal, o_Stall);
        end
        n_vec++;
        if ((o_Rs1 | o_Rs2 | o_Immediate) !== 64'd0) begin
            n_err++;
            $display("FAIL reset_data: got rs1=%h rs2=%h imm=%h, want 0", o_Rs1, o_Rs2, o_Immediate);
        end
        #9 i_Rst_n = 1'b1;
    endtask

    task automatic test_addi();
        cycle(32'h00700093, 1, 0, 64'h1111, 64'h2222);
        n_vec++;
        if ({o_Valid, o_ALUctl, o_ALUsrc, o_RdAddr, o_RegWrite} !== {1'b1, 4'b0010, 1'b1, 5'd1, 1'b1}) begin
            n_err++;
            $display("FAIL addi_ctl: got valid=%b ctl=%b src=%b rd=%0d rw=%b, want 1 0010 1 1 1",
                     o_Valid, o_ALUctl, o_ALUsrc, o_RdAddr, o_RegWrite);
        end
        n_vec++;
        if (o_Immediate !== 64'd7) begin
            n_err++;
            $display("FAIL addi_imm: got %h want 7", o_Immediate);
        end
    endtask

    task automatic test_r_type();
        cycle(32'h002081B3, 1, 0, 64'd5, 64'd7);
        n_vec++;
        if ({o_Rs1, o_Rs2, o_ALUsrc, o_ALUctl} !== {64'd5, 64'd7, 1'b0, 4'b0010}) begin
            n_err++;
            $display("FAIL add_rr: got rs1=%0d rs2=%0d src=%b ctl=%b, want 5 7 0 0010",
                     o_Rs1, o_Rs2, o_ALUsrc, o_ALUctl);
        end
        cycle(32'h402081B3, 1, 0, 64'd5, 64'd7);
        n_vec++;
        if ({o_ALUctl, o_ALUsrc, o_RegWrite, o_Valid} !== {4'b0110, 1'b0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL sub_rr: got ctl=%b src=%b rw=%b valid=%b, want 0110 0 1 1",
                     o_ALUctl, o_ALUsrc, o_RegWrite, o_Valid);
        end
    endtask

    task automatic test_store();
        cycle(32'h0020B423, 1, 0, 64'd100, 64'd200);
        n_vec++;
        if ({o_Immediate, o_MemWrite, o_RegWrite, o_ALUsrc} !== {64'd8, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL sd_pos: got imm=%h mw=%b rw=%b src=%b, want 8 1 0 1",
                     o_Immediate, o_MemWrite, o_RegWrite, o_ALUsrc);
        end
        cycle(enc_s(12'hFF8, 5'd2, 5'd1), 1, 0, 64'd100, 64'd200);
        n_vec++;
        if (o_Immediate !== 64'hFFFF_FFFF_FFFF_FFF8) begin
            n_err++;
            $display("FAIL sd_neg: got imm=%h want fffffffffffffff8", o_Immediate);
        end
    endtask

    task automatic test_load_use();
        cycle(32'h0000B283, 1, 0, 64'd40, 64'd0);
        n_vec++;
        if ({o_Valid, o_MemRead, o_RdAddr} !== {1'b1, 1'b1, 5'd5}) begin
            n_err++;
            $display("FAIL ld_issue: got valid=%b mr=%b rd=%0d, want 1 1 5", o_Valid, o_MemRead, o_RdAddr);
        end
        cycle(32'h00228333, 1, 0, 64'd1, 64'd2);
        n_vec++;
        if ({obs_stall, o_Valid, o_RegWrite} !== 3'b100) begin
            n_err++;
            $display("FAIL lu_stall: got stall=%b valid=%b rw=%b, want 1 0 0", obs_stall, o_Valid, o_RegWrite);
        end
        cycle(32'h00228333, 1, 0, 64'd3, 64'd4);
        n_vec++;
        if ({obs_stall, o_Valid, o_RdAddr, o_ALUctl, o_Rs1} !== {1'b0, 1'b1, 5'd6, 4'b0010, 64'd3}) begin
            n_err++;
            $display("FAIL lu_issue: got stall=%b valid=%b rd=%0d ctl=%b rs1=%0d, want 0 1 6 0010 3",
                     obs_stall, o_Valid, o_RdAddr, o_ALUctl, o_Rs1);
        end
        // Load to x0 followed by a reader of x0: no hazard.
        cycle(32'h0000B003, 1, 0, 64'd0, 64'd0);
        cycle(32'h00200333, 1, 0, 64'd0, 64'd9);
        n_vec++;
        if ({obs_stall, o_Valid} !== 2'b01) begin
            n_err++;
            $display("FAIL lu_x0: got stall=%b valid=%b, want 0 1", obs_stall, o_Valid);
        end
        // Chained loads: LD x5; LD x6,0(x5); ADD x7,x6,x0 - each dependent stalls once.
        cycle(32'h0000B283, 1, 0, 64'd0, 64'd0);
        cycle(32'h0002B303, 1, 0, 64'd0, 64'd0);
        n_vec++;
        if ({obs_stall, o_Valid} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_stall1: got stall=%b valid=%b, want 1 0", obs_stall, o_Valid);
        end
        cycle(32'h0002B303, 1, 0, 64'd0, 64'd0);
        n_vec++;
        if ({obs_stall, o_Valid, o_MemRead, o_RdAddr} !== {3'b011, 5'd6}) begin
            n_err++;
            $display("FAIL b2b_ld2: got stall=%b valid=%b mr=%b rd=%0d, want 0 1 1 6",
                     obs_stall, o_Valid, o_MemRead, o_RdAddr);
        end
        cycle(enc_r(7'h00, 5'd0, 5'd6, 3'd0, 5'd7), 1, 0, 64'd0, 64'd0);
        n_vec++;
        if ({obs_stall, o_Valid} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_stall2: got stall=%b valid=%b, want 1 0", obs_stall, o_Valid);
        end
        cycle(enc_r(7'h00, 5'd0, 5'd6, 3'd0, 5'd7), 1, 0, 64'd0, 64'd0);
        n_vec++;
        if ({obs_stall, o_Valid, o_RdAddr} !== {2'b01, 5'd7}) begin
            n_err++;
            $display("FAIL b2b_add: got stall=%b valid=%b rd=%0d, want 0 1 7", obs_stall, o_Valid, o_RdAddr);
        end
    endtask

    task automatic test_flush();
        cycle(32'h002081B3, 1, 1, 64'd5, 64'd7);
        n_vec++;
        if ({o_Valid, o_RegWrite} !== 2'b00) begin
            n_err++;
            $display("FAIL flush_add: got valid=%b rw=%b, want 0 0", o_Valid, o_RegWrite);
        end
        cycle(32'h0000B283, 1, 0, 64'd0, 64'd0);
        cycle(32'h00228333, 1, 1, 64'd0, 64'd0);
        n_vec++;
        if ({obs_stall, o_Valid} !== 2'b00) begin
            n_err++;
            $display("FAIL flush_stall: got stall=%b valid=%b, want 0 0", obs_stall, o_Valid);
        end
        cycle(32'h00228333, 1, 0, 64'd11, 64'd0);
        n_vec++;
        if ({obs_stall, o_Valid, o_RdAddr} !== {2'b01, 5'd6}) begin
            n_err++;
            $display("FAIL flush_resume: got stall=%b valid=%b rd=%0d, want 0 1 6", obs_stall, o_Valid, o_RdAddr);
        end
    endtask

    task automatic test_async_reset();
        cycle(32'h0000B283, 1, 0, 64'hABCD, 64'h1234);
        i_Instr = 32'h00228333; i_Valid = 1; i_Flush = 0;
        #2;
        n_vec++;
        if (o_Stall !== 1'b1) begin
            n_err++;
            $display("FAIL ar_prestall: got stall=%b want 1", o_Stall);
        end
        #1 i_Rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({o_Valid, o_ALUctl, o_ALUsrc, o_RdAddr, o_RegWrite, o_MemRead, o_MemWrite,
             o_Branch, o_Illegal, o_Stall} !== 17'd0 || (o_Rs1 | o_Rs2 | o_Immediate) !== 64'd0) begin
            n_err++;
            $display("FAIL async_reset: got valid=%b ctl=%b mr=%b rd=%0d stall=%b rs1=%h imm=%h, want all 0",
                     o_Valid, o_ALUctl, o_MemRead, o_RdAddr, o_Stall, o_Rs1, o_Immediate);
        end
        @(posedge i_Clk);
        #1 i_Rst_n = 1'b1;
        cycle(32'h00228333, 1, 0, 64'd21, 64'd22);
        n_vec++;
        if ({obs_stall, o_Valid, o_RdAddr, o_Rs2} !== {2'b01, 5'd6, 64'd22}) begin
            n_err++;
            $display("FAIL ar_replay: got stall=%b valid=%b rd=%0d rs2=%0d, want 0 1 6 22",
                     obs_stall, o_Valid, o_RdAddr, o_Rs2);
        end
    endtask

    task automatic test_illegal();
        cycle(32'hFFFFFFFF, 1, 0, 64'd0, 64'd0);
        n_vec++;
        if ({o_Illegal, o_Valid, o_RegWrite, o_MemWrite, o_MemRead, o_Branch, o_ALUctl} !==
            {6'b110000, 4'b0010}) begin
            n_err++;
            $display("FAIL illegal: got ill=%b valid=%b rw=%b mw=%b mr=%b br=%b ctl=%b, want 1 1 0 0 0 0 0010",
                     o_Illegal, o_Valid, o_RegWrite, o_MemWrite, o_MemRead, o_Branch, o_ALUctl);
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0]  a, b, d;
        logic [11:0] im;
        logic [31:0] r;
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        d  = 5'($urandom_range(0, 7));
        im = 12'($urandom);
        case ($urandom_range(0, 11))
            0:  return enc_r(7'h00, b, a, 3'd0, d);
            1:  return enc_r(7'h20, b, a, 3'd0, d);
            2:  return enc_r(7'h00, b, a, 3'd7, d);
            3:  return enc_r(7'h00, b, a, 3'd6, d);
            4:  return enc_i(im, a, 3'd0, d, 7'h13);
            5:  return enc_i(im, a, ($urandom_range(0, 1) != 0) ? 3'd7 : 3'd6, d, 7'h13);
            6, 7: return enc_i(im, a, 3'd3, d, 7'h03);
            8:  return enc_s(im, b, a);
            9:  return enc_b({im, 1'b0}, b, a);
            10: begin
                r = $urandom;
                r[6:0] = 7'h7F;
                return r;
            end
            default: return enc_r(7'h00, b, a, 3'd4, d);
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] ins;
        bit v, fl, hold;
        hold = 0;
        ins  = gen_instr();
        for (int n = 0; n < 600; n++) begin
            if (!hold) ins = gen_instr();
            v  = hold || ($urandom_range(0, 99) < 88);
            fl = ($urandom_range(0, 99) < 7);
            cycle(ins, v, fl, {$urandom, $urandom}, {$urandom, $urandom});
            hold = exp_stall;
            n_vec++;
            if (obs_stall !== exp_stall) begin
                n_err++;
                $display("FAIL rnd_stall[%0d]: instr=%h got %b want %b", n, ins, obs_stall, exp_stall);
            end
            n_vec++;
            if ({o_Valid, o_RegWrite, o_MemRead, o_MemWrite, o_Branch, o_Illegal} !==
                {m_valid, m_rw, m_mr, m_mw, m_br, m_ill}) begin
                n_err++;
                $display("FAIL rnd_ctl[%0d]: instr=%h got v/rw/mr/mw/br/ill=%b%b%b%b%b%b want %b%b%b%b%b%b",
                         n, ins, o_Valid, o_RegWrite, o_MemRead, o_MemWrite, o_Branch, o_Illegal,
                         m_valid, m_rw, m_mr, m_mw, m_br, m_ill);
            end
            if (m_valid) begin
                n_vec++;
                if ({o_ALUctl, o_RdAddr} !== {m_aluctl, m_rd}) begin
                    n_err++;
                    $display("FAIL rnd_alu_rd[%0d]: instr=%h got ctl=%b rd=%0d want ctl=%b rd=%0d",
                             n, ins, o_ALUctl, o_RdAddr, m_aluctl, m_rd);
                end
            end
            if (m_valid && !m_ill) begin
                n_vec++;
                if ({o_ALUsrc, o_Rs1, o_Rs2, o_Immediate} !== {m_alusrc, m_rs1, m_rs2, m_imm}) begin
                    n_err++;
                    $display("FAIL rnd_data[%0d]: instr=%h got src=%b rs1=%h rs2=%h imm=%h want src=%b rs1=%h rs2=%h imm=%h",
                             n, ins, o_ALUsrc, o_Rs1, o_Rs2, o_Immediate, m_alusrc, m_rs1, m_rs2, m_imm);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_r_type();
        test_store();
        test_load_use();
        test_flush();
        test_async_reset();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
